instr_fetch_buf: RTL

Upstream stage of the tt_um_example processor core, between the chip pins and the execute datapath.
- Byte-serial program loader: captures up to DEPTH 8-bit instructions from ui_in into an internal buffer.
- Fetch engine: sequences the buffered instructions to the core over a valid/ready handshake.
- Honours branch redirects from the core; halts at end of program.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/instr_buf_mem.sv | 21 ++
 rtl/instr_fetch_buf.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
package fetch_pkg;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_IW    = 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/instr_buf_mem.sv
// DEPTH x IW instruction store: synchronous write, asynchronous read, no reset.
module instr_buf_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_buf.sv
// Byte-serial program loader plus fetch sequencer with branch redirect.
// Build option FETCH_LOOP_EN: end-of-program handshake wraps pc to 0 instead of halting.
module instr_fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = DEF_IW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  input  logic          run,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_len,
  output logic          busy,
  output logic          halted
);
  localparam logic [AW:0] LEN_LAST = (AW+1)'(DEPTH - 1);

  fetch_state_t  state;
  logic          wr_en;
  logic [IW-1:0] rdata;
  logic [AW:0]   pc_inc;

  // Writes stop once the buffer is full; a load_valid at prog_len == DEPTH is dropped.
  assign wr_en  = (state == LOAD) && load_valid && !prog_len[AW];
  assign pc_inc = {1'b0, pc} + (AW+1)'(1);

  instr_buf_mem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (prog_len[AW-1:0]),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      prog_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            prog_len <= '0;
          end else if (run) begin
            if (prog_len != '0) begin
              state <= RUN;
              pc    <= '0;
            end else begin
              state <= HALT;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            prog_len <= prog_len + (AW+1)'(1);
            if (load_last || prog_len == LEN_LAST) state <= IDLE;
          end
        end
        RUN: begin
          if (branch_valid) begin
            if ({1'b0, branch_target} < prog_len) pc <= branch_target;
            else                                  state <= HALT;
          end else if (instr_ready) begin
            if (pc_inc == prog_len) begin
`ifdef FETCH_LOOP_EN
              pc <= '0;
`else
              state <= HALT;
`endif
            end else begin
              pc <= pc_inc[AW-1:0];
            end
          end
        end
        HALT: begin
          if (load_start) begin
            state    <= LOAD;
            prog_len <= '0;
          end else if (run && prog_len != '0) begin
            // Re-run is only meaningful with a program present.
            state <= RUN;
            pc    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_valid = (state == RUN);
  assign instr_out   = instr_valid ? rdata : '0;
  assign busy        = (state == LOAD) || (state == RUN);
  assign halted      = (state == HALT);
endmodule
